// File: rtl/gunluk_islem_sirali_pkg.sv
// Shared types and constants for the daily operation sequencer and the station it drives.
package istasyon_pkg;

  typedef enum logic [1:0] {
    YUKLE   = 2'd0,
    SIFIRLA = 2'd1,
    OYNAT   = 2'd2,
    BITTI   = 2'd3
  } durum_t;

  localparam logic [1:0] ISLEM_0 = 2'd0;
  localparam logic [1:0] ISLEM_1 = 2'd1;
  localparam logic [1:0] ISLEM_2 = 2'd2;
  localparam logic [1:0] ISLEM_3 = 2'd3;

  localparam int unsigned GUN_MAX = 31;
  localparam int unsigned GUN_W   = 5;

endpackage

// File: rtl/gunluk_islem_sirali_if.sv
// Plan write port: valid/ready handshake carrying one 2-bit operation per transfer.
interface gunluk_islem_sirali_if;

  logic       yaz_gecerli;
  logic [1:0] yaz_islem;
  logic       yaz_hazir;

  modport master (
    output yaz_gecerli,
    output yaz_islem,
    input  yaz_hazir
  );

  modport slave (
    input  yaz_gecerli,
    input  yaz_islem,
    output yaz_hazir
  );

endinterface

// File: rtl/plan_bellek.sv
// Plan storage: DERINLIK x 2-bit register file, one synchronous write, one asynchronous read.
module plan_bellek
  import istasyon_pkg::*;
#(
  parameter int unsigned DERINLIK = 30
) (
  input  logic             saat,
  input  logic             yaz_en,
  input  logic [GUN_W-1:0] yaz_adres,
  input  logic [1:0]       yaz_veri,
  input  logic [GUN_W-1:0] oku_adres,
  output logic [1:0]       oku_veri
);

  localparam logic [GUN_W-1:0] SINIR = GUN_W'(DERINLIK);

  logic [1:0] mem_q [DERINLIK];

  always_ff @(posedge saat) begin
    if (yaz_en && (yaz_adres < SINIR)) begin
      mem_q[yaz_adres] <= yaz_veri;
    end
  end

  // Out-of-range addresses read as zero so the last-day lookahead stays in bounds.
  assign oku_veri = (oku_adres < SINIR) ? mem_q[oku_adres] : '0;

endmodule

// File: rtl/gunluk_islem_sirali.sv
// Daily operation sequencer: loads a plan, resets the station, then plays one operation per day.
module gunluk_islem_sirali
  import istasyon_pkg::*;
#(
  parameter int unsigned GUN_SAYISI = 30
) (
  input  logic                   saat,
  input  logic                   reset,
  gunluk_islem_sirali_if.slave   yaz,
  input  logic                   temizle,
  input  logic                   baslat,
  input  logic                   amorti,
  output logic [1:0]             islem,
  output logic                   istasyon_reset,
  output logic [GUN_W-1:0]       gun,
  output logic [GUN_W-1:0]       kayitli,
  output logic                   calisiyor,
  output logic                   bitti
);

  localparam logic [GUN_W-1:0] KAPASITE = GUN_W'(GUN_SAYISI);

  durum_t           durum_q, durum_d;
  logic [GUN_W-1:0] kayitli_q, kayitli_d;
  logic [GUN_W-1:0] uzunluk_q, uzunluk_d;
  logic [GUN_W-1:0] gun_q, gun_d;
  logic [1:0]       islem_q, islem_d;
  logic             ist_reset_q, ist_reset_d;
  logic             bitti_q, bitti_d;

  logic             yaz_en;
  logic [GUN_W-1:0] yaz_sonrasi;
  logic [GUN_W-1:0] oku_adres;
  logic [1:0]       oku_veri;

  assign yaz.yaz_hazir = (durum_q == YUKLE) && (kayitli_q < KAPASITE);

  // gun_q is 1-based, so it addresses the entry for the following day directly.
  assign oku_adres = (durum_q == OYNAT) ? gun_q : '0;

  plan_bellek #(
    .DERINLIK (GUN_SAYISI)
  ) u_plan_bellek (
    .saat      (saat),
    .yaz_en    (yaz_en),
    .yaz_adres (kayitli_q),
    .yaz_veri  (yaz.yaz_islem),
    .oku_adres (oku_adres),
    .oku_veri  (oku_veri)
  );

  always_comb begin
    durum_d     = durum_q;
    kayitli_d   = kayitli_q;
    uzunluk_d   = uzunluk_q;
    gun_d       = '0;
    islem_d     = '0;
    ist_reset_d = 1'b0;
    bitti_d     = 1'b0;
    yaz_en      = 1'b0;
    yaz_sonrasi = kayitli_q;

    unique case (durum_q)
      YUKLE: begin
        if (temizle) begin
          kayitli_d = '0;
        end else begin
          yaz_en      = yaz.yaz_gecerli && yaz.yaz_hazir;
          yaz_sonrasi = kayitli_q + {{(GUN_W-1){1'b0}}, yaz_en};
          kayitli_d   = yaz_sonrasi;
          if (baslat && (yaz_sonrasi != '0)) begin
            uzunluk_d   = yaz_sonrasi;
            durum_d     = SIFIRLA;
            ist_reset_d = 1'b1;
          end
        end
      end
      SIFIRLA: begin
        durum_d = OYNAT;
        gun_d   = GUN_W'(1);
        islem_d = oku_veri;
      end
      OYNAT: begin
        if (amorti || (gun_q >= uzunluk_q)) begin
          durum_d = BITTI;
          bitti_d = 1'b1;
        end else begin
          gun_d   = gun_q + GUN_W'(1);
          islem_d = oku_veri;
        end
      end
      BITTI: begin
        durum_d = YUKLE;
      end
      default: begin
        durum_d = YUKLE;
      end
    endcase
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      durum_q     <= YUKLE;
      kayitli_q   <= '0;
      uzunluk_q   <= '0;
      gun_q       <= '0;
      islem_q     <= '0;
      ist_reset_q <= 1'b0;
      bitti_q     <= 1'b0;
    end else begin
      durum_q     <= durum_d;
      kayitli_q   <= kayitli_d;
      uzunluk_q   <= uzunluk_d;
      gun_q       <= gun_d;
      islem_q     <= islem_d;
      ist_reset_q <= ist_reset_d;
      bitti_q     <= bitti_d;
    end
  end

  assign islem          = islem_q;
  assign istasyon_reset = ist_reset_q;
  assign gun            = gun_q;
  assign kayitli        = kayitli_q;
  assign calisiyor      = (durum_q == SIFIRLA) || (durum_q == OYNAT);
  assign bitti          = bitti_q;

endmodule

// File: tb/tb_gunluk_islem_sirali.sv
// Scoreboard bench: expected (islem, gun) days are queued at start and consumed as days appear.
module tb_gunluk_islem_sirali;
  import istasyon_pkg::*;

  logic             saat;
  logic             reset;
  logic             temizle;
  logic             baslat;
  logic             amorti;
  logic [1:0]       islem;
  logic             istasyon_reset;
  logic [GUN_W-1:0] gun;
  logic [GUN_W-1:0] kayitli;
  logic             calisiyor;
  logic             bitti;

  gunluk_islem_sirali_if yif ();

  gunluk_islem_sirali #(
    .GUN_SAYISI (30)
  ) dut (
    .saat           (saat),
    .reset          (reset),
    .yaz            (yif.slave),
    .temizle        (temizle),
    .baslat         (baslat),
    .amorti         (amorti),
    .islem          (islem),
    .istasyon_reset (istasyon_reset),
    .gun            (gun),
    .kayitli        (kayitli),
    .calisiyor      (calisiyor),
    .bitti          (bitti)
  );

  typedef struct {
    logic [1:0]       islem;
    logic [GUN_W-1:0] gun;
  } beklenen_t;

  beklenen_t   kuyruk[$];
  int unsigned n_karsilastirma = 0;
  int unsigned n_hata          = 0;
  logic [1:0]  plan[$];

  initial begin
    saat = 1'b0;
    forever #5 saat = ~saat;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: gozlenen=timeout beklenen=finish");
    $fatal(1);
  end

  task automatic kontrol(input string tag, input int unsigned gozlenen, input int unsigned beklenen);
    n_karsilastirma++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: gozlenen=%0d beklenen=%0d", tag, gozlenen, beklenen);
    end
  endtask

  // Every driven day must match the head of the scoreboard.
  always @(negedge saat) begin
    if (!reset && gun != '0) begin
      if (kuyruk.size() == 0) begin
        kontrol("fazla_gun", gun, 0);
      end else begin
        beklenen_t b;
        b = kuyruk.pop_front();
        kontrol("gun", gun, b.gun);
        kontrol("islem", islem, b.islem);
        kontrol("gunde_ist_reset", istasyon_reset, 0);
      end
    end
  end

  task automatic bos(input int n);
    repeat (n) begin
      @(posedge saat);
      #1;
    end
  endtask

  task automatic yaz_ver(input logic [1:0] op);
    yif.yaz_gecerli = 1'b1;
    yif.yaz_islem   = op;
    @(posedge saat);
    #1;
    yif.yaz_gecerli = 1'b0;
  endtask

  task automatic temizle_ver();
    temizle = 1'b1;
    @(posedge saat);
    #1;
    temizle = 1'b0;
  endtask

  task automatic baslat_ver();
    baslat = 1'b1;
    @(posedge saat);
    #1;
    baslat = 1'b0;
  endtask

  task automatic plani_kuyruga(input int unsigned gun_sayisi);
    for (int unsigned i = 0; i < gun_sayisi; i++) begin
      beklenen_t b;
      b.islem = plan[i];
      b.gun   = GUN_W'(i + 1);
      kuyruk.push_back(b);
    end
  endtask

  task automatic bitti_bekle();
    logic bulundu;
    bulundu = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge saat);
      if (bitti) begin
        bulundu = 1'b1;
        break;
      end
    end
    kontrol("bitti_geldi", bulundu, 1);
    kontrol("bitti_islem", islem, 0);
    kontrol("bitti_gun", gun, 0);
    @(posedge saat);
    #1;
  endtask

  task automatic gun_bekle(input logic [GUN_W-1:0] g);
    logic bulundu;
    bulundu = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge saat);
      if (gun == g) begin
        bulundu = 1'b1;
        break;
      end
    end
    kontrol("gun_bekle", bulundu, 1);
  endtask

  initial begin
    reset           = 1'b1;
    temizle         = 1'b0;
    baslat          = 1'b0;
    amorti          = 1'b0;
    yif.yaz_gecerli = 1'b0;
    yif.yaz_islem   = '0;
    #12;
    kontrol("rst_islem", islem, 0);
    kontrol("rst_ist_reset", istasyon_reset, 0);
    kontrol("rst_gun", gun, 0);
    kontrol("rst_kayitli", kayitli, 0);
    kontrol("rst_calisiyor", calisiyor, 0);
    kontrol("rst_bitti", bitti, 0);
    kontrol("rst_yaz_hazir", yif.yaz_hazir, 1);
    @(posedge saat);
    #1;
    reset = 1'b0;

    // Basic playback 1,2,3
    plan = '{2'd1, 2'd2, 2'd3};
    foreach (plan[i]) yaz_ver(plan[i]);
    kontrol("temel_kayitli", kayitli, 3);
    plani_kuyruga(3);
    baslat_ver();
    kontrol("temel_ist_reset", istasyon_reset, 1);
    kontrol("temel_calisiyor", calisiyor, 1);
    kontrol("temel_sifirla_gun", gun, 0);
    bos(1);
    kontrol("temel_gun1", gun, 1);
    kontrol("temel_ist_reset_bitti", istasyon_reset, 0);
    bitti_bekle();
    kontrol("temel_yaz_hazir", yif.yaz_hazir, 1);
    kontrol("temel_kayitli_sonra", kayitli, 3);
    kontrol("temel_kuyruk", kuyruk.size(), 0);

    // Full buffer: 31 writes into capacity 30
    temizle_ver();
    plan.delete();
    for (int i = 0; i < 31; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (i < 30) plan.push_back(op);
      yaz_ver(op);
      if (i == 29) begin
        kontrol("dolu_kayitli30", kayitli, 30);
        kontrol("dolu_yaz_hazir", yif.yaz_hazir, 0);
      end
    end
    kontrol("dolu_kayitli31", kayitli, 30);
    plani_kuyruga(30);
    baslat_ver();
    bitti_bekle();
    kontrol("dolu_kuyruk", kuyruk.size(), 0);

    // Early stop on day 4
    temizle_ver();
    plan.delete();
    for (int i = 0; i < 10; i++) begin
      plan.push_back(2'd2);
      yaz_ver(2'd2);
    end
    plani_kuyruga(4);
    baslat_ver();
    gun_bekle(GUN_W'(4));
    amorti = 1'b1;
    @(posedge saat);
    #1;
    amorti = 1'b0;
    kontrol("erken_bitti", bitti, 1);
    kontrol("erken_gun", gun, 0);
    bos(3);
    kontrol("erken_kuyruk", kuyruk.size(), 0);
    kontrol("erken_kayitli", kayitli, 10);

    // baslat with empty plan
    temizle_ver();
    baslat_ver();
    kontrol("bos_baslat_ist_reset", istasyon_reset, 0);
    kontrol("bos_baslat_calisiyor", calisiyor, 0);
    bos(2);

    // temizle + baslat with 5 stored
    for (int i = 0; i < 5; i++) yaz_ver(2'd1);
    kontrol("tb_kayitli5", kayitli, 5);
    temizle = 1'b1;
    baslat  = 1'b1;
    @(posedge saat);
    #1;
    temizle = 1'b0;
    baslat  = 1'b0;
    kontrol("tb_kayitli0", kayitli, 0);
    kontrol("tb_calisiyor", calisiyor, 0);
    bos(2);

    // write + baslat with 2 stored -> 3-day plan
    plan = '{2'd3, 2'd0, 2'd1};
    yaz_ver(plan[0]);
    yaz_ver(plan[1]);
    plani_kuyruga(3);
    yif.yaz_gecerli = 1'b1;
    yif.yaz_islem   = plan[2];
    baslat          = 1'b1;
    @(posedge saat);
    #1;
    yif.yaz_gecerli = 1'b0;
    baslat          = 1'b0;
    kontrol("yb_ist_reset", istasyon_reset, 1);
    kontrol("yb_kayitli", kayitli, 3);
    bitti_bekle();
    kontrol("yb_kuyruk", kuyruk.size(), 0);

    // Replay a 4-day plan twice
    temizle_ver();
    plan.delete();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      plan.push_back(op);
      yaz_ver(op);
    end
    for (int r = 0; r < 2; r++) begin
      plani_kuyruga(4);
      baslat_ver();
      bitti_bekle();
      kontrol("tekrar_kuyruk", kuyruk.size(), 0);
    end
    kontrol("tekrar_kayitli", kayitli, 4);

    // Async reset on day 5 of a 10-day plan
    temizle_ver();
    plan.delete();
    for (int i = 0; i < 10; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(1, 3));
      plan.push_back(op);
      yaz_ver(op);
    end
    plani_kuyruga(5);
    baslat_ver();
    gun_bekle(GUN_W'(5));
    #2;
    reset = 1'b1;
    #1;
    kontrol("ar_islem", islem, 0);
    kontrol("ar_gun", gun, 0);
    kontrol("ar_kayitli", kayitli, 0);
    kontrol("ar_calisiyor", calisiyor, 0);
    kontrol("ar_bitti", bitti, 0);
    kontrol("ar_yaz_hazir", yif.yaz_hazir, 1);
    @(posedge saat);
    #1;
    reset = 1'b0;
    baslat_ver();
    kontrol("ar_baslat_ist_reset", istasyon_reset, 0);
    kontrol("ar_baslat_calisiyor", calisiyor, 0);
    bos(3);
    kontrol("ar_kuyruk", kuyruk.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_hata);
    $finish;
  end

endmodule
